// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: decoded control bundle layout, bubble value and opcodes.
package mips_pkg;

  localparam int CTRL_W = 13;

  // Bit offsets of each control field inside the packed bundle (MSB first).
  localparam int CTRL_REGWRITE  = 12;
  localparam int CTRL_REGDST    = 11;
  localparam int CTRL_ALUSRC_HI = 10;
  localparam int CTRL_ALUSRC_LO = 9;
  localparam int CTRL_BRANCH    = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_JUMP      = 5;
  localparam int CTRL_ALUOP_HI  = 4;
  localparam int CTRL_ALUOP_LO  = 1;
  localparam int CTRL_BRANCHNOT = 0;

  typedef struct packed {
    logic       regwrite;
    logic       regdst;
    logic [1:0] alusrc;
    logic       branch;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic [3:0] aluop;
    logic       branchnot;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = 13'b0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/load_use_hazard.sv
// Load-use hazard detection: a load in EX whose destination feeds the ID instruction.
module load_use_hazard #(
  parameter int REG_AW = 5
) (
  input  logic              valid_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              flush_e,
  input  logic              hold_e,
  output logic              stall_d
);

  logic hazard;

  // $0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard  = valid_e & memtoreg_e & (rt_e != '0) & ((rt_e == rs_d) | (rt_e == rt_d));
  assign stall_d = hazard & ~flush_e & ~hold_e;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a bubble counter.
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               regwrite_d,
  input  logic               regdst_d,
  input  logic               branch_d,
  input  logic               memwrite_d,
  input  logic               memtoreg_d,
  input  logic               jump_d,
  input  logic               branchnot_d,
  input  logic [1:0]         alusrc_d,
  input  logic [ALUOP_W-1:0] aluop_d,
  input  logic [DATA_W-1:0]  rd1_d,
  input  logic [DATA_W-1:0]  rd2_d,
  input  logic [DATA_W-1:0]  signimm_d,
  input  logic [DATA_W-1:0]  pcplus4_d,
  input  logic [REG_AW-1:0]  rs_d,
  input  logic [REG_AW-1:0]  rt_d,
  input  logic [REG_AW-1:0]  rd_d,
  input  logic               flush_e,
  input  logic               hold_e,
  output logic               regwrite_e,
  output logic               regdst_e,
  output logic               branch_e,
  output logic               memwrite_e,
  output logic               memtoreg_e,
  output logic               jump_e,
  output logic               branchnot_e,
  output logic [1:0]         alusrc_e,
  output logic [ALUOP_W-1:0] aluop_e,
  output logic [DATA_W-1:0]  rd1_e,
  output logic [DATA_W-1:0]  rd2_e,
  output logic [DATA_W-1:0]  signimm_e,
  output logic [DATA_W-1:0]  pcplus4_e,
  output logic [REG_AW-1:0]  rs_e,
  output logic [REG_AW-1:0]  rt_e,
  output logic [REG_AW-1:0]  rd_e,
  output logic               valid_e,
  output logic               stall_d,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  assign ctrl_d = '{
    regwrite:  regwrite_d,
    regdst:    regdst_d,
    alusrc:    alusrc_d,
    branch:    branch_d,
    memwrite:  memwrite_d,
    memtoreg:  memtoreg_d,
    jump:      jump_d,
    aluop:     aluop_d,
    branchnot: branchnot_d
  };

  load_use_hazard #(.REG_AW(REG_AW)) u_hazard (
    .valid_e    (valid_e),
    .memtoreg_e (ctrl_q.memtoreg),
    .rt_e       (rt_e),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .flush_e    (flush_e),
    .hold_e     (hold_e),
    .stall_d    (stall_d)
  );

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= CTRL_BUBBLE;
      rd1_e      <= '0;
      rd2_e      <= '0;
      signimm_e  <= '0;
      pcplus4_e  <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      valid_e    <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush_e || (!hold_e && stall_d)) begin
      // Flush and load-use both insert a bubble; only the load-use one is counted.
      ctrl_q    <= CTRL_BUBBLE;
      rd1_e     <= '0;
      rd2_e     <= '0;
      signimm_e <= '0;
      pcplus4_e <= '0;
      rs_e      <= '0;
      rt_e      <= '0;
      rd_e      <= '0;
      valid_e   <= 1'b0;
      if (!flush_e && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end else if (!hold_e) begin
      ctrl_q    <= ctrl_d;
      rd1_e     <= rd1_d;
      rd2_e     <= rd2_d;
      signimm_e <= signimm_d;
      pcplus4_e <= pcplus4_d;
      rs_e      <= rs_d;
      rt_e      <= rt_d;
      rd_e      <= rd_d;
      valid_e   <= 1'b1;
    end
  end

  assign regwrite_e  = ctrl_q.regwrite;
  assign regdst_e    = ctrl_q.regdst;
  assign alusrc_e    = ctrl_q.alusrc;
  assign branch_e    = ctrl_q.branch;
  assign memwrite_e  = ctrl_q.memwrite;
  assign memtoreg_e  = ctrl_q.memtoreg;
  assign jump_e      = ctrl_q.jump;
  assign aluop_e     = ctrl_q.aluop;
  assign branchnot_e = ctrl_q.branchnot;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: instruction-level model plus directed literal checks.
module tb_id_ex_pipe_reg;
  import mips_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 8;  // narrow counter so saturation is reachable quickly
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic reset;
  ctrl_t d_ctrl;
  logic [DATA_W-1:0] rd1_d, rd2_d, signimm_d, pcplus4_d;
  logic [REG_AW-1:0] rs_d, rt_d, rd_d;
  logic flush_e, hold_e;

  logic regwrite_e, regdst_e, branch_e, memwrite_e, memtoreg_e, jump_e, branchnot_e;
  logic [1:0] alusrc_e;
  logic [3:0] aluop_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, signimm_e, pcplus4_e;
  logic [REG_AW-1:0] rs_e, rt_e, rd_e;
  logic valid_e, stall_d;
  logic [CNT_W-1:0] bubble_cnt;

  int checks = 0;
  int failures = 0;
  bit compare_en = 1'b0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .regwrite_d(d_ctrl.regwrite), .regdst_d(d_ctrl.regdst), .branch_d(d_ctrl.branch),
    .memwrite_d(d_ctrl.memwrite), .memtoreg_d(d_ctrl.memtoreg), .jump_d(d_ctrl.jump),
    .branchnot_d(d_ctrl.branchnot), .alusrc_d(d_ctrl.alusrc), .aluop_d(d_ctrl.aluop),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d), .pcplus4_d(pcplus4_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .flush_e(flush_e), .hold_e(hold_e),
    .regwrite_e(regwrite_e), .regdst_e(regdst_e), .branch_e(branch_e),
    .memwrite_e(memwrite_e), .memtoreg_e(memtoreg_e), .jump_e(jump_e),
    .branchnot_e(branchnot_e), .alusrc_e(alusrc_e), .aluop_e(aluop_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .signimm_e(signimm_e), .pcplus4_e(pcplus4_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .valid_e(valid_e), .stall_d(stall_d),
    .bubble_cnt(bubble_cnt)
  );

  // Model: the instruction occupying EX, or an empty slot, plus a bubble tally.
  typedef struct {
    bit                valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] rd1, rd2, imm, pc;
    logic [REG_AW-1:0] rs, rt, rd;
  } slot_t;

  slot_t m_ex;
  int    m_bubbles;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0; s.ctrl = '0;
    s.rd1 = '0; s.rd2 = '0; s.imm = '0; s.pc = '0;
    s.rs = '0; s.rt = '0; s.rd = '0;
    return s;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = m_ex.valid && m_ex.ctrl.memtoreg && (m_ex.rt != 0) && (m_ex.rt == rs_d || m_ex.rt == rt_d);
    return dep && !flush_e && !hold_e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ex = empty_slot();
      m_bubbles = 0;
    end else if (flush_e) begin
      m_ex = empty_slot();
    end else if (hold_e) begin
      m_ex = m_ex;
    end else if (model_stall()) begin
      m_ex = empty_slot();
      if (m_bubbles < int'(CNT_MAX)) m_bubbles = m_bubbles + 1;
    end else begin
      m_ex.valid = 1'b1; m_ex.ctrl = d_ctrl;
      m_ex.rd1 = rd1_d; m_ex.rd2 = rd2_d; m_ex.imm = signimm_d; m_ex.pc = pcplus4_d;
      m_ex.rs = rs_d; m_ex.rt = rt_d; m_ex.rd = rd_d;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  ctrl_t dut_ctrl;
  assign dut_ctrl = '{regwrite: regwrite_e, regdst: regdst_e, alusrc: alusrc_e, branch: branch_e,
                      memwrite: memwrite_e, memtoreg: memtoreg_e, jump: jump_e, aluop: aluop_e,
                      branchnot: branchnot_e};

  always @(negedge clk) begin
    if (compare_en) begin
      check("cmp_valid", 64'(valid_e), 64'(m_ex.valid));
      check("cmp_ctrl", 64'(dut_ctrl), 64'(m_ex.ctrl));
      check("cmp_rd1", 64'(rd1_e), 64'(m_ex.rd1));
      check("cmp_rd2", 64'(rd2_e), 64'(m_ex.rd2));
      check("cmp_imm", 64'(signimm_e), 64'(m_ex.imm));
      check("cmp_pc", 64'(pcplus4_e), 64'(m_ex.pc));
      check("cmp_regs", 64'({rs_e, rt_e, rd_e}), 64'({m_ex.rs, m_ex.rt, m_ex.rd}));
      check("cmp_stall", 64'(stall_d), 64'(model_stall()));
      check("cmp_cnt", 64'(bubble_cnt), 64'(m_bubbles));
    end
  end

  function automatic ctrl_t mk_lw();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.alusrc = 2'b01; c.memtoreg = 1'b1; c.aluop = 4'b0010;
    return c;
  endfunction

  function automatic ctrl_t mk_add();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.regdst = 1'b1; c.aluop = 4'b0010;
    return c;
  endfunction

  function automatic ctrl_t mk_addi();
    ctrl_t c = '0;
    c.regwrite = 1'b1; c.alusrc = 2'b01; c.aluop = 4'b0010;
    return c;
  endfunction

  task automatic drive(input ctrl_t c, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] rd, input logic [DATA_W-1:0] rd1,
                       input logic [DATA_W-1:0] imm);
    d_ctrl = c; rs_d = rs; rt_d = rt; rd_d = rd;
    rd1_d = rd1; rd2_d = rd1 ^ 32'h0F0F_0000; signimm_d = imm; pcplus4_d = 32'h0040_0000 + imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush_e = 1'b0; hold_e = 1'b0;
    drive(mk_lw(), 5'd3, 5'd8, 5'd4, 32'hDEAD_BEEF, 32'h1234);
    #12;
    check("rst_valid", 64'(valid_e), 64'd0);
    check("rst_regwrite", 64'(regwrite_e), 64'd0);
    check("rst_rd1", 64'(rd1_e), 64'd0);
    check("rst_cnt", 64'(bubble_cnt), 64'd0);
    #5 reset = 1'b1;
    compare_en = 1'b1;

    // ADDI pass-through
    drive(mk_addi(), 5'd1, 5'd2, 5'd0, 32'h5, 32'h7);
    step();
    check("addi_regwrite", 64'(regwrite_e), 64'd1);
    check("addi_alusrc", 64'(alusrc_e), 64'b01);
    check("addi_rd1", 64'(rd1_e), 64'h5);
    check("addi_imm", 64'(signimm_e), 64'h7);
    check("addi_valid", 64'(valid_e), 64'd1);

    // Mid-cycle asynchronous reset with live, non-zero inputs
    drive(mk_lw(), 5'd7, 5'd9, 5'd6, 32'hCAFE_F00D, 32'h44);
    #1 reset = 1'b0;
    #1;
    check("async_valid", 64'(valid_e), 64'd0);
    check("async_regwrite", 64'(regwrite_e), 64'd0);
    check("async_rd1", 64'(rd1_e), 64'd0);
    check("async_stall", 64'(stall_d), 64'd0);
    #4 reset = 1'b1;

    // Load-use on rs
    drive(mk_lw(), 5'd29, 5'd8, 5'd0, 32'h100, 32'h10);
    step();
    drive(mk_add(), 5'd8, 5'd3, 5'd9, 32'h22, 32'h0);
    #1;
    check("lu_stall", 64'(stall_d), 64'd1);
    step();
    check("lu_bubble_valid", 64'(valid_e), 64'd0);
    check("lu_bubble_ctrl", 64'(dut_ctrl), 64'd0);
    check("lu_cnt", 64'(bubble_cnt), 64'd1);
    check("lu_stall_drop", 64'(stall_d), 64'd0);
    step();
    check("lu_add_valid", 64'(valid_e), 64'd1);
    check("lu_add_rs", 64'(rs_e), 64'd8);

    // No hazard: load into $0
    drive(mk_lw(), 5'd5, 5'd0, 5'd0, 32'h1, 32'h2);
    step();
    drive(mk_add(), 5'd0, 5'd0, 5'd11, 32'h3, 32'h0);
    #1;
    check("zero_reg_stall", 64'(stall_d), 64'd0);

    // No hazard: unrelated specifiers, then rt-side dependency
    drive(mk_lw(), 5'd5, 5'd8, 5'd0, 32'h1, 32'h2);
    step();
    drive(mk_add(), 5'd9, 5'd10, 5'd12, 32'h3, 32'h0);
    #1;
    check("nodep_stall", 64'(stall_d), 64'd0);
    drive(mk_add(), 5'd9, 5'd8, 5'd12, 32'h3, 32'h0);
    #1;
    check("rt_dep_stall", 64'(stall_d), 64'd1);
    step();

    // Flush beats hazard
    drive(mk_lw(), 5'd5, 5'd8, 5'd0, 32'h1, 32'h2);
    step();
    drive(mk_add(), 5'd8, 5'd1, 5'd2, 32'h3, 32'h0);
    flush_e = 1'b1;
    #1;
    check("flush_stall", 64'(stall_d), 64'd0);
    step();
    flush_e = 1'b0;
    check("flush_valid", 64'(valid_e), 64'd0);
    check("flush_cnt", 64'(bubble_cnt), 64'd2);

    // Hold freezes EX and masks the stall until released
    drive(mk_lw(), 5'd5, 5'd8, 5'd0, 32'hAAAA, 32'h2);
    step();
    hold_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk_add(), 5'd8, 5'd1, 5'd2, 32'h1000 + 32'(i), 32'h0);
      #1;
      check("hold_stall", 64'(stall_d), 64'd0);
      step();
      check("hold_rd1", 64'(rd1_e), 64'hAAAA);
      check("hold_valid", 64'(valid_e), 64'd1);
    end
    hold_e = 1'b0;
    #1;
    check("unhold_stall", 64'(stall_d), 64'd1);
    step();
    check("unhold_cnt", 64'(bubble_cnt), 64'd3);

    // Drive the counter to saturation
    for (int i = 0; i < 260; i++) begin
      drive(mk_lw(), 5'd5, 5'd8, 5'd0, 32'(i), 32'h2);
      step();
      drive(mk_add(), 5'd8, 5'd1, 5'd2, 32'h3, 32'h0);
      step();
    end
    check("sat_cnt", 64'(bubble_cnt), 64'(CNT_MAX));
    drive(mk_lw(), 5'd5, 5'd8, 5'd0, 32'h9, 32'h2);
    step();
    drive(mk_add(), 5'd8, 5'd1, 5'd2, 32'h3, 32'h0);
    #1;
    check("sat_stall", 64'(stall_d), 64'd1);
    step();
    check("sat_hold_cnt", 64'(bubble_cnt), 64'(CNT_MAX));
    check("sat_bubble_valid", 64'(valid_e), 64'd0);

    step();
    compare_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
